// File: rtl/rob_multi.sv
// rob_multi: reorder buffer with in-order dispatch, multi-port writeback and wide in-order retire.
// Optional ROB_WB_BYPASS_EN: read ports also see same-cycle wakeup/writeback.
module rob_multi #(
    parameter int N_ENTRIES      = 16,
    parameter int RETIRE_WIDTH   = 2,
    parameter int N_WB_PORTS     = 2,
    parameter int N_RD_PORTS     = 2,
    parameter int REG_DATA_WIDTH = 32,
    parameter int ARF_ID_WIDTH   = 5,
    parameter int ADDR_WIDTH     = 32,
    localparam int ID_W          = $clog2(N_ENTRIES)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   dispatch_valid,
    output logic                                   dispatch_ready,
    output logic [ID_W-1:0]                        dispatch_rob_id,
    input  logic                                   dispatch_dst_valid,
    input  logic [ARF_ID_WIDTH-1:0]                dispatch_dst_arf_id,
    input  logic [ADDR_WIDTH-1:0]                  dispatch_pc,
    input  logic [N_WB_PORTS-1:0]                  wakeup_valid,
    input  logic [N_WB_PORTS*ID_W-1:0]             wakeup_rob_id,
    input  logic [N_WB_PORTS-1:0]                  wb_valid,
    input  logic [N_WB_PORTS*ID_W-1:0]             wb_rob_id,
    input  logic [N_WB_PORTS*REG_DATA_WIDTH-1:0]   wb_reg_data,
    input  logic [N_WB_PORTS-1:0]                  wb_npc_valid,
    input  logic [N_WB_PORTS-1:0]                  wb_mispred,
    input  logic [N_WB_PORTS*ADDR_WIDTH-1:0]       wb_npc,
    input  logic [N_RD_PORTS*ID_W-1:0]             rd_rob_id,
    output logic [N_RD_PORTS-1:0]                  rd_ready,
    output logic [N_RD_PORTS*REG_DATA_WIDTH-1:0]   rd_data,
    output logic [RETIRE_WIDTH-1:0]                retire_valid,
    output logic [RETIRE_WIDTH*ID_W-1:0]           retire_rob_id,
    output logic [RETIRE_WIDTH-1:0]                retire_dst_valid,
    output logic [RETIRE_WIDTH*ARF_ID_WIDTH-1:0]   retire_arf_id,
    output logic [RETIRE_WIDTH*REG_DATA_WIDTH-1:0] retire_reg_data,
    output logic                                   redirect_valid,
    output logic [ADDR_WIDTH-1:0]                  redirect_pc,
    output logic [ID_W:0]                          occupancy
);

    localparam int PTR_W = ID_W + 1;

    logic [PTR_W-1:0]          head;
    logic [PTR_W-1:0]          tail;
    logic [N_ENTRIES-1:0]      busy;
    logic [N_ENTRIES-1:0]      dst_valid;
    logic [N_ENTRIES-1:0]      reg_ready;
    logic [N_ENTRIES-1:0]      done;
    logic [N_ENTRIES-1:0]      br_mispred;
    logic [ARF_ID_WIDTH-1:0]   arf_id   [N_ENTRIES];
    logic [ADDR_WIDTH-1:0]     pc_npc   [N_ENTRIES];
    logic [REG_DATA_WIDTH-1:0] reg_data [N_ENTRIES];

    logic             full;
    logic             dispatch_fire;
    logic [PTR_W-1:0] n_retired;

    assign full            = (head[ID_W-1:0] == tail[ID_W-1:0]) && (head[ID_W] != tail[ID_W]);
    assign dispatch_ready  = !full && !redirect_valid;
    assign dispatch_fire   = dispatch_valid && dispatch_ready;
    assign dispatch_rob_id = tail[ID_W-1:0];
    assign occupancy       = tail - head;

    // Retire window: a mispredicted branch commits but closes the window behind it.
    always_comb begin
        logic [ID_W-1:0] slot_idx;
        logic            chain;
        retire_valid     = '0;
        retire_rob_id    = '0;
        retire_dst_valid = '0;
        retire_arf_id    = '0;
        retire_reg_data  = '0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        n_retired        = '0;
        slot_idx         = '0;
        chain            = 1'b1;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            slot_idx = head[ID_W-1:0] + ID_W'(k);
            retire_rob_id[k*ID_W +: ID_W]                     = slot_idx;
            retire_arf_id[k*ARF_ID_WIDTH +: ARF_ID_WIDTH]     = arf_id[slot_idx];
            retire_reg_data[k*REG_DATA_WIDTH +: REG_DATA_WIDTH] = reg_data[slot_idx];
            if (chain && busy[slot_idx] && done[slot_idx]) begin
                retire_valid[k]     = 1'b1;
                retire_dst_valid[k] = dst_valid[slot_idx];
                n_retired           = n_retired + PTR_W'(1);
                if (br_mispred[slot_idx]) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = pc_npc[slot_idx];
                    chain          = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

    always_comb begin
        logic [ID_W-1:0] rid;
        rd_ready = '0;
        rd_data  = '0;
        rid      = '0;
        for (int r = 0; r < N_RD_PORTS; r++) begin
            rid         = rd_rob_id[r*ID_W +: ID_W];
            rd_ready[r] = busy[rid] && reg_ready[rid];
            rd_data[r*REG_DATA_WIDTH +: REG_DATA_WIDTH] = reg_data[rid];
`ifdef ROB_WB_BYPASS_EN
            for (int p = 0; p < N_WB_PORTS; p++) begin
                if (wakeup_valid[p] && wakeup_rob_id[p*ID_W +: ID_W] == rid && busy[rid])
                    rd_ready[r] = 1'b1;
            end
            // Later ports override earlier ones, matching the storage priority.
            for (int p = 0; p < N_WB_PORTS; p++) begin
                if (wb_valid[p] && wb_rob_id[p*ID_W +: ID_W] == rid && busy[rid]) begin
                    rd_ready[r] = 1'b1;
                    rd_data[r*REG_DATA_WIDTH +: REG_DATA_WIDTH] =
                        wb_reg_data[p*REG_DATA_WIDTH +: REG_DATA_WIDTH];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            busy <= '0;
        end else begin
            for (int p = 0; p < N_WB_PORTS; p++) begin
                if (wakeup_valid[p] && busy[wakeup_rob_id[p*ID_W +: ID_W]])
                    reg_ready[wakeup_rob_id[p*ID_W +: ID_W]] <= 1'b1;
            end
            for (int p = 0; p < N_WB_PORTS; p++) begin
                if (wb_valid[p] && busy[wb_rob_id[p*ID_W +: ID_W]]) begin
                    reg_ready[wb_rob_id[p*ID_W +: ID_W]] <= 1'b1;
                    done[wb_rob_id[p*ID_W +: ID_W]]      <= 1'b1;
                    reg_data[wb_rob_id[p*ID_W +: ID_W]]  <=
                        wb_reg_data[p*REG_DATA_WIDTH +: REG_DATA_WIDTH];
                    if (wb_npc_valid[p]) begin
                        pc_npc[wb_rob_id[p*ID_W +: ID_W]]     <= wb_npc[p*ADDR_WIDTH +: ADDR_WIDTH];
                        br_mispred[wb_rob_id[p*ID_W +: ID_W]] <= wb_mispred[p];
                    end
                end
            end
            if (dispatch_fire) begin
                busy[tail[ID_W-1:0]]       <= 1'b1;
                dst_valid[tail[ID_W-1:0]]  <= dispatch_dst_valid;
                arf_id[tail[ID_W-1:0]]     <= dispatch_dst_arf_id;
                reg_ready[tail[ID_W-1:0]]  <= 1'b0;
                done[tail[ID_W-1:0]]       <= 1'b0;
                br_mispred[tail[ID_W-1:0]] <= 1'b0;
                pc_npc[tail[ID_W-1:0]]     <= dispatch_pc;
            end
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (retire_valid[k])
                    busy[retire_rob_id[k*ID_W +: ID_W]] <= 1'b0;
            end
            head <= head + n_retired;
            if (redirect_valid) begin
                busy <= '0;
                tail <= head + n_retired;
            end else if (dispatch_fire) begin
                tail <= tail + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: a reference ROB model plus an in-order scoreboard of dispatched
// instructions, checked every cycle against retire/redirect/dispatch/occupancy outputs.
module tb_rob_multi;
    localparam int N  = 16;
    localparam int RW = 2;
    localparam int NW = 2;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PW = 32;
    localparam int IW = 4;

    logic               clk;
    logic               rst;
    logic               dispatch_valid;
    logic               dispatch_ready;
    logic [IW-1:0]      dispatch_rob_id;
    logic               dispatch_dst_valid;
    logic [AW-1:0]      dispatch_dst_arf_id;
    logic [PW-1:0]      dispatch_pc;
    logic [NW-1:0]      wakeup_valid;
    logic [NW*IW-1:0]   wakeup_rob_id;
    logic [NW-1:0]      wb_valid;
    logic [NW*IW-1:0]   wb_rob_id;
    logic [NW*DW-1:0]   wb_reg_data;
    logic [NW-1:0]      wb_npc_valid;
    logic [NW-1:0]      wb_mispred;
    logic [NW*PW-1:0]   wb_npc;
    logic [NR*IW-1:0]   rd_rob_id;
    logic [NR-1:0]      rd_ready;
    logic [NR*DW-1:0]   rd_data;
    logic [RW-1:0]      retire_valid;
    logic [RW*IW-1:0]   retire_rob_id;
    logic [RW-1:0]      retire_dst_valid;
    logic [RW*AW-1:0]   retire_arf_id;
    logic [RW*DW-1:0]   retire_reg_data;
    logic               redirect_valid;
    logic [PW-1:0]      redirect_pc;
    logic [IW:0]        occupancy;

    rob_multi dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_rob_id(dispatch_rob_id), .dispatch_dst_valid(dispatch_dst_valid),
        .dispatch_dst_arf_id(dispatch_dst_arf_id), .dispatch_pc(dispatch_pc),
        .wakeup_valid(wakeup_valid), .wakeup_rob_id(wakeup_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_reg_data(wb_reg_data),
        .wb_npc_valid(wb_npc_valid), .wb_mispred(wb_mispred), .wb_npc(wb_npc),
        .rd_rob_id(rd_rob_id), .rd_ready(rd_ready), .rd_data(rd_data),
        .retire_valid(retire_valid), .retire_rob_id(retire_rob_id),
        .retire_dst_valid(retire_dst_valid), .retire_arf_id(retire_arf_id),
        .retire_reg_data(retire_reg_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [4:0] arf;
        logic       dv;
    } sb_t;

    sb_t         sb[$];
    bit          m_busy [N];
    bit          m_done [N];
    bit          m_misp [N];
    logic [31:0] m_data [N];
    logic [31:0] m_npc  [N];
    int          m_head, m_tail, m_occ, seq;
    int          vectors = 0;
    int          fails   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_done[i] = 0; m_misp[i] = 0;
        end
        m_head = 0; m_tail = 0; m_occ = 0;
        sb.delete();
    endtask

    task automatic clear_inputs();
        rst = 1'b0;
        dispatch_valid = 1'b0;
        wakeup_valid = '0;
        wb_valid = '0;
        wb_npc_valid = '0;
        wb_mispred = '0;
    endtask

    task automatic do_dispatch();
        dispatch_valid      = 1'b1;
        dispatch_pc         = 32'h1000 + 32'(seq * 4);
        dispatch_dst_arf_id = 5'(seq + 1);
        dispatch_dst_valid  = (seq % 3) != 0;
    endtask

    task automatic set_wb(input int p, input int id, input logic [31:0] d,
                          input logic nv, input logic mp, input logic [31:0] npc);
        wb_valid[p]              = 1'b1;
        wb_rob_id[p*IW +: IW]    = IW'(id);
        wb_reg_data[p*DW +: DW]  = d;
        wb_npc_valid[p]          = nv;
        wb_mispred[p]            = mp;
        wb_npc[p*PW +: PW]       = npc;
    endtask

    // Check outputs before the edge, advance the model across it, then release pulse inputs.
    task automatic tick();
        logic [RW-1:0] er;
        int            n, id;
        bit            redir, chain, acc;
        logic [31:0]   rpc;
        sb_t           e;
        @(negedge clk);
        er = '0; n = 0; redir = 0; chain = 1; rpc = '0;
        for (int k = 0; k < RW; k++) begin
            id = (m_head + k) % N;
            if (chain && m_busy[id] && m_done[id]) begin
                er[k] = 1'b1; n++;
                if (m_misp[id]) begin redir = 1; rpc = m_npc[id]; chain = 0; end
            end else chain = 0;
        end
        chk("retire_valid", 64'(retire_valid), 64'(er));
        chk("redirect_valid", 64'(redirect_valid), 64'(redir));
        if (redir) chk("redirect_pc", 64'(redirect_pc), 64'(rpc));
        chk("occupancy", 64'(occupancy), 64'(m_occ));
        chk("dispatch_ready", 64'(dispatch_ready), 64'(m_occ < N && !redir));
        chk("dispatch_rob_id", 64'(dispatch_rob_id), 64'(m_tail % N));
        for (int k = 0; k < n; k++) begin
            if (sb.size() > 0) e = sb.pop_front();
            else e = '{id: -1, arf: '0, dv: 1'b0};
            chk("retire_id", 64'(retire_rob_id[k*IW +: IW]), 64'(e.id));
            chk("retire_dst_valid", 64'(retire_dst_valid[k]), 64'(e.dv));
            if (e.dv) chk("retire_arf", 64'(retire_arf_id[k*AW +: AW]), 64'(e.arf));
            if (e.id >= 0) chk("retire_data", 64'(retire_reg_data[k*DW +: DW]), 64'(m_data[e.id]));
        end
        acc = dispatch_valid && m_occ < N && !redir;
        if (rst) begin
            model_reset();
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (wb_valid[p]) begin
                    id = int'(wb_rob_id[p*IW +: IW]);
                    if (m_busy[id]) begin
                        m_done[id] = 1; m_data[id] = wb_reg_data[p*DW +: DW];
                        if (wb_npc_valid[p]) begin
                            m_npc[id] = wb_npc[p*PW +: PW]; m_misp[id] = wb_mispred[p];
                        end
                    end
                end
            end
            for (int k = 0; k < n; k++) m_busy[(m_head + k) % N] = 0;
            m_head = (m_head + n) % (2 * N);
            if (redir) begin
                for (int i = 0; i < N; i++) m_busy[i] = 0;
                m_tail = m_head; m_occ = 0;
                sb.delete();
            end else begin
                m_occ = m_occ - n;
                if (acc) begin
                    id = m_tail % N;
                    m_busy[id] = 1; m_done[id] = 0; m_misp[id] = 0; m_npc[id] = dispatch_pc;
                    sb.push_back('{id: id, arf: dispatch_dst_arf_id, dv: dispatch_dst_valid});
                    m_tail = (m_tail + 1) % (2 * N);
                    m_occ++; seq++;
                end
            end
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        seq = 0;
        model_reset();
        clear_inputs();
        dispatch_pc = '0; dispatch_dst_arf_id = '0; dispatch_dst_valid = 1'b0;
        wakeup_rob_id = '0; wb_rob_id = '0; wb_reg_data = '0; wb_npc = '0;
        rd_rob_id = '0;
        rst = 1'b1;
        tick();
        #2;
        chk("reset_rd_ready", 64'(rd_ready), 64'(0));

        // Fill to 16; a 17th request stays pending.
        for (int i = 0; i < 17; i++) begin do_dispatch(); tick(); end
        tick();
        chk("full_occupancy", 64'(occupancy), 64'(16));

        // Reset while full, with writebacks and a dispatch in flight.
        set_wb(0, 2, 32'hDEAD, 1'b0, 1'b0, '0);
        set_wb(1, 5, 32'hBEEF, 1'b1, 1'b1, 32'h900);
        do_dispatch();
        rst = 1'b1;
        tick();
        tick();

        // Two-wide retire, then a hole at id 2 blocks id 3.
        for (int i = 0; i < 4; i++) begin do_dispatch(); tick(); end
        set_wb(0, 1, 32'hA, 1'b0, 1'b0, '0);
        set_wb(1, 0, 32'hB, 1'b0, 1'b0, '0);
        tick();
        tick();
        set_wb(0, 3, 32'hC, 1'b0, 1'b0, '0);
        tick();
        tick();
        set_wb(0, 2, 32'hD, 1'b0, 1'b0, '0);
        tick();
        tick();

        // Mispredict at id 5 with younger entries already done.
        do_dispatch(); tick();
        set_wb(0, 4, 32'h44, 1'b0, 1'b0, '0);
        tick();
        for (int i = 0; i < 5; i++) begin do_dispatch(); tick(); end
        set_wb(0, 6, 32'h66, 1'b0, 1'b0, '0);
        set_wb(1, 7, 32'h77, 1'b0, 1'b0, '0);
        tick();
        set_wb(0, 8, 32'h88, 1'b0, 1'b0, '0);
        set_wb(1, 9, 32'h99, 1'b0, 1'b0, '0);
        tick();
        set_wb(0, 5, 32'h55, 1'b1, 1'b1, 32'h400);
        tick();
        tick();
        #2;
        chk("flush_rob_id", 64'(dispatch_rob_id), 64'(6));
        chk("flush_occupancy", 64'(occupancy), 64'(0));

        // Read-port timing against same-cycle writeback and wakeup.
        rst = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin do_dispatch(); tick(); end
        rd_rob_id = {4'd0, 4'd3};
        set_wb(1, 3, 32'h55, 1'b0, 1'b0, '0);
        #2;
`ifdef ROB_WB_BYPASS_EN
        chk("rd_bypass_ready", 64'(rd_ready[0]), 64'(1));
        chk("rd_bypass_data", 64'(rd_data[DW-1:0]), 64'(32'h55));
`else
        chk("rd_nobypass_ready", 64'(rd_ready[0]), 64'(0));
`endif
        chk("rd_unready", 64'(rd_ready[1]), 64'(0));
        tick();
        #2;
        chk("rd_next_ready", 64'(rd_ready[0]), 64'(1));
        chk("rd_next_data", 64'(rd_data[DW-1:0]), 64'(32'h55));
        rd_rob_id = {4'd2, 4'd3};
        wakeup_valid[0] = 1'b1;
        wakeup_rob_id[IW-1:0] = 4'd2;
        #2;
`ifdef ROB_WB_BYPASS_EN
        chk("rd_wakeup_bypass", 64'(rd_ready[1]), 64'(1));
`else
        chk("rd_wakeup_same", 64'(rd_ready[1]), 64'(0));
`endif
        tick();
        #2;
        chk("rd_wakeup_next", 64'(rd_ready[1]), 64'(1));

        // Streaming dispatch/retire across the pointer wrap.
        rst = 1'b1; tick();
        for (int i = 0; i < 40; i++) begin
            do_dispatch();
            if (i > 0) set_wb(i % 2, (m_tail + N - 1) % N, $urandom, 1'b0, 1'b0, '0);
            tick();
        end
        set_wb(0, (m_tail + N - 1) % N, $urandom, 1'b0, 1'b0, '0);
        tick();
        tick();
        tick();
        chk("stream_drained", 64'(sb.size()), 64'(0));
        chk("stream_wrap_tail", 64'(dispatch_rob_id), 64'(40 % N));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
